// File: rtl/router_out_arbiter_pkg.sv
// Shared types and constants for the router output-link arbiter.
package router_out_arbiter_pkg;

  localparam int unsigned PKT_BYTES = 4;
  localparam int unsigned BYTE_W    = 8;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t StIdle = 1'b0;
  localparam arb_state_t StSend = 1'b1;

endpackage

// File: rtl/router_out_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above prio_ptr_i, wrapping.
module router_out_arbiter_rr_picker #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [PTR_W-1:0]  prio_ptr_i,
  output logic [NUM_IN-1:0] winner_o,
  output logic [PTR_W-1:0]  winner_idx_o,
  output logic              valid_o
);

  int unsigned        idx;
  logic [PTR_W-1:0]   sel;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    valid_o      = 1'b0;
    idx          = 0;
    sel          = '0;
    for (int unsigned off = 0; off < NUM_IN; off++) begin
      // Explicit wrap keeps non-power-of-two NUM_IN in range.
      idx = 32'(prio_ptr_i) + off;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end
      sel = PTR_W'(idx);
      if (!valid_o && req_i[sel]) begin
        valid_o       = 1'b1;
        winner_o[sel] = 1'b1;
        winner_idx_o  = sel;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Round-robin arbiter sharing one byte-serial output link between NUM_IN input buffers.
module router_out_arbiter
  import router_out_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IN-1:0]   req,
  input  pkt_t [NUM_IN-1:0]   pkt_in,
  output logic [NUM_IN-1:0]   grant,
  input  logic                free_outbound,
  output logic                put_outbound,
  output logic [BYTE_W-1:0]   payload_outbound,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_sent_cnt
);

  localparam int unsigned PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned PKT_W = $bits(pkt_t);

  arb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   prio_q, prio_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic               free_seen_low_q, free_seen_low_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_IN-1:0]  pick_winner;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               start;

  router_out_arbiter_rr_picker #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req_i        (req),
    .prio_ptr_i   (prio_q),
    .winner_o     (pick_winner),
    .winner_idx_o (pick_idx),
    .valid_o      (pick_valid)
  );

  // free_seen_low_q blocks a stale free (lagging put by a cycle) from starting a second packet.
  assign start = (state_q == StIdle) && free_outbound && free_seen_low_q && pick_valid && !rst;
  assign grant = start ? pick_winner : '0;

  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    byte_idx_d      = byte_idx_q;
    shift_d         = shift_q;
    free_seen_low_d = free_seen_low_q;
    cnt_d           = cnt_q;

    if (!free_outbound) begin
      free_seen_low_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d         = pkt_in[pick_idx];
          prio_d          = (pick_idx == PTR_W'(NUM_IN - 1)) ? '0 : pick_idx + PTR_W'(1);
          free_seen_low_d = 1'b0;
          byte_idx_d      = 2'd0;
          state_d         = StSend;
        end
      end
      StSend: begin
        shift_d = shift_q >> BYTE_W;
        if (byte_idx_q == 2'(PKT_BYTES - 1)) begin
          byte_idx_d = 2'd0;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = StIdle;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      prio_q          <= '0;
      byte_idx_q      <= 2'd0;
      shift_q         <= '0;
      free_seen_low_q <= 1'b1;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      prio_q          <= prio_d;
      byte_idx_q      <= byte_idx_d;
      shift_q         <= shift_d;
      free_seen_low_q <= free_seen_low_d;
      cnt_q           <= cnt_d;
    end
  end

  assign busy             = (state_q == StSend);
  assign put_outbound     = busy;
  assign payload_outbound = busy ? shift_q[BYTE_W-1:0] : '0;
  assign pkt_sent_cnt     = cnt_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Randomized bench for router_out_arbiter with a packet-level reference model and byte scoreboard.
module tb_router_out_arbiter;
  import router_out_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  pkt_t [N-1:0]  pkt_in = '0;
  logic [N-1:0]  grant;
  logic          free = 1'b0;
  logic          put_outbound;
  logic [7:0]    payload_outbound;
  logic          busy;
  logic [CW-1:0] pkt_sent_cnt;

  always #5 clk = ~clk;

  router_out_arbiter #(
    .NUM_IN (N),
    .CNT_W  (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .pkt_in           (pkt_in),
    .grant            (grant),
    .free_outbound    (free),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .busy             (busy),
    .pkt_sent_cnt     (pkt_sent_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // Reference model: link is either idle or has m_rem bytes left to emit.
  int m_ptr;
  bit m_fsl;
  int m_rem;
  int m_cnt;

  // Stimulus control; input changes happen only in the drive slot of step().
  int           free_mode;  // 0 random, 1 lagged receiver, 2 force low, 3 force high, 4 lagged+random
  bit           auto_req;
  bit           hold_req;
  logic [N-1:0] nx_set, nx_clr, granted_prev;
  pkt_t         nx_pkt [N];
  bit           last_put;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_fsl = 1'b1;
    m_rem = 0;
    m_cnt = 0;
    granted_prev = '0;
    exp_q.delete();
  endtask

  task automatic model_eval();
    logic [N-1:0] eg;
    bit           start;
    int           w;
    eg = '0;
    w  = -1;
    check("busy", 32'(busy), 32'(m_rem > 0));
    check("put", 32'(put_outbound), 32'(m_rem > 0));
    check("cnt", 32'(pkt_sent_cnt), 32'(m_cnt));
    start = (m_rem == 0) && free && m_fsl && (req != '0);
    if (start) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && req[i]) w = i;
      end
      eg[w] = 1'b1;
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(8'((pkt_in[w] >> (8 * b)) & 32'hff));
      end
      m_ptr = (w + 1) % N;
      m_fsl = 1'b0;
      m_rem = 4;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (!free) m_fsl = 1'b1;
    check("grant", 32'(grant), 32'(eg));
    granted_prev = eg;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    case (free_mode)
      0:       free = ($urandom_range(0, 3) != 0);
      1:       free = !last_put;
      2:       free = 1'b0;
      3:       free = 1'b1;
      default: free = !last_put && ($urandom_range(0, 3) != 0);
    endcase
    last_put = put_outbound;
    req = req & ~nx_clr;
    if (!hold_req) req = req & ~granted_prev;
    for (int i = 0; i < N; i++) begin
      if (nx_set[i]) begin
        req[i]    = 1'b1;
        pkt_in[i] = nx_pkt[i];
      end else if (auto_req) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]    = 1'b1;
          pkt_in[i] = pkt_t'($urandom);
        end else if (req[i] && $urandom_range(0, 30) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    nx_set = '0;
    nx_clr = '0;
    #1;
    model_eval();
  endtask

  task automatic drain();
    auto_req  = 1'b0;
    hold_req  = 1'b0;
    free_mode = 1;
    nx_clr    = '1;
    step();
    for (int k = 0; k < 20 && m_rem != 0; k++) step();
    check("drain_done", 32'(m_rem), 32'd0);
    step();
    step();
  endtask

  // Monitor: every put cycle pops one expected byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (put_outbound) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_put: got byte %0h expected no put at %0t", payload_outbound, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("payload", 32'(payload_outbound), 32'(e));
        end
      end else begin
        check("idle_payload", 32'(payload_outbound), 32'd0);
      end
    end
  end

  initial begin
    nx_set    = '0;
    nx_clr    = '0;
    auto_req  = 1'b0;
    hold_req  = 1'b0;
    free_mode = 3;
    last_put  = 1'b0;
    model_reset();
    #1;
    check("rst_put", 32'(put_outbound), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(pkt_sent_cnt), 32'd0);
    #11 rst = 1'b0;

    // Single request with a known packet.
    nx_set    = 4'b0010;
    nx_pkt[1] = pkt_t'(32'hA1B2C3D4);
    for (int k = 0; k < 7; k++) step();

    // Backpressure then release.
    drain();
    free_mode = 2;
    nx_set    = 4'b0100;
    nx_pkt[2] = pkt_t'($urandom);
    for (int k = 0; k < 10; k++) step();
    free_mode = 3;
    step();
    free_mode = 1;
    for (int k = 0; k < 8; k++) step();

    // Request rising during the second byte.
    drain();
    nx_set    = 4'b0010;
    nx_pkt[1] = pkt_t'($urandom);
    step();
    step();
    nx_set    = 4'b1000;
    nx_pkt[3] = pkt_t'($urandom);
    for (int k = 0; k < 12; k++) step();

    // Fairness with all requests held, lagged receiver free.
    drain();
    hold_req = 1'b1;
    nx_set   = 4'b1111;
    for (int i = 0; i < N; i++) nx_pkt[i] = pkt_t'($urandom);
    for (int k = 0; k < 40; k++) step();

    // Randomized traffic.
    drain();
    auto_req = 1'b1;
    for (int blk = 0; blk < 15; blk++) begin
      case (blk % 3)
        0:       free_mode = 0;
        1:       free_mode = 1;
        default: free_mode = 4;
      endcase
      for (int k = 0; k < 200; k++) step();
    end
    drain();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a packet from input 1 (leaves prio_ptr at 2).
    nx_set    = 4'b0010;
    nx_pkt[1] = pkt_t'($urandom);
    step();
    for (int k = 0; k < 20 && m_rem != 2; k++) step();
    check("reached_byte1", 32'(m_rem), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_put", 32'(put_outbound), 32'd0);
    check("midrst_payload", 32'(payload_outbound), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    req  = '0;
    free = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cnt", 32'(pkt_sent_cnt), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    #1 rst = 1'b0;
    last_put  = 1'b0;
    free_mode = 3;
    nx_set    = 4'b1001;
    nx_pkt[0] = pkt_t'($urandom);
    nx_pkt[3] = pkt_t'($urandom);
    step();
    free_mode = 1;
    for (int k = 0; k < 14; k++) step();
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Shares one router output link (byte-serial put/free handshake toward a node) between NUM_IN router input buffers.
- Each input buffer presents a full 32-bit pkt_t and a request. The block picks a winner by round-robin and pulses that requester's grant, which the requester uses as its clear_data_available.
- It then serializes the packet as PKT_BYTES bytes, LSB byte first, on put_outbound/payload_outbound.
- It sits inside the router, between the node_to_router input buffers and the node-facing output link.

Parameters:
- NUM_IN, 4, number of requesting input buffers (2..8).
- CNT_W, 16, width of the delivered-packet counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_IN  req[i]=1: input buffer i holds a valid packet.
- pkt_in  input  NUM_IN x 32 (pkt_t array)  packet offered by each buffer; must be stable while req[i]=1.
- grant  output  NUM_IN  one-hot, single-cycle pulse; packet i has been accepted.
- free_outbound  input  1  receiving node is ready for a new packet.
- put_outbound  output  1  a valid byte is on payload_outbound this cycle.
- payload_outbound  output  8  serialized packet byte.
- busy  output  1  high in SEND state.
- pkt_sent_cnt  output  CNT_W  count of packets fully serialized; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1, takes effect immediately):
  - state=IDLE, prio_ptr=0, byte_idx=0, shift register=0, free_seen_low=1.
  - Outputs: put_outbound=0, payload_outbound=0, grant=0, busy=0, pkt_sent_cnt=0.
- States: IDLE, SEND.
- IDLE, start condition = free_outbound=1 AND free_seen_low=1 AND |req.
  - When the start condition holds, the winner is the first i with req[i]=1, searching from prio_ptr upward modulo NUM_IN.
  - In the same cycle: grant[winner]=1 (combinational from registered state and inputs), pkt_in[winner] is latched at the edge, prio_ptr <= (winner+1) mod NUM_IN, free_seen_low <= 0, next state is SEND.
  - Without the start condition: stay in IDLE, grant=0, prio_ptr unchanged.
- SEND:
  - put_outbound=1 (registered) and payload_outbound=packet[8*byte_idx +: 8] for byte_idx = 0, 1, 2, 3 on 4 consecutive cycles.
  - free_outbound is not sampled for flow control during SEND; it only gates the start of a packet.
  - On the byte_idx=3 cycle: byte_idx <= 0, pkt_sent_cnt <= pkt_sent_cnt+1, next state is IDLE.
- free_seen_low:
  - Set whenever free_outbound=0 is sampled in any state.
  - Cleared at packet start.
  - Purpose: a stale free_outbound=1 (the receiver's registered free lags put by one cycle) must never start a second packet.
- Latency: req sampled at cycle T with the start condition true gives grant at T, bytes 0..3 at T+1..T+4, IDLE at T+5. The earliest next grant is the first cycle with free_outbound=1 after free_outbound has been low.
- payload_outbound=0 whenever put_outbound=0.
- busy=1 exactly when in SEND; grant is never asserted while busy=1.
- A requester that drops req without a grant is simply skipped. A req[i] that rises during SEND is considered at the next IDLE.
- If req=0 for every i, prio_ptr holds its value.
- Reset mid-SEND: put drops immediately, and the partially sent packet is lost with its grant already issued. The receiving node must itself be reset with the router.
- Width rules:
  - prio_ptr is $clog2(NUM_IN) bits; the modulo wrap is explicit for non-power-of-two NUM_IN.
  - byte_idx is 2 bits.
  - pkt_sent_cnt wraps silently.

Decomposition:
- Shared package (e.g. noc_pkg):
  - pkt_t as a 32-bit packed struct {src[3:0], dest[3:0], data[23:0]}.
  - PKT_BYTES=4.
  - BYTE_W=8.
  - The arbiter state enum.
- Sub-module rr_picker (purely combinational): inputs req and prio_ptr; outputs a one-hot winner and its index.
- router_out_arbiter holds prio_ptr, the FSM, the shift/serializer register and the counter.

Test Plan:
- Single request: free=1, req=4'b0010, pkt_in[1]=32'hA1B2C3D4 → grant=4'b0010 for 1 cycle; next 4 cycles put=1, payload D4, C3, B2, A1; pkt_sent_cnt=1.
- Round-robin fairness: req=4'b1111 held, receiver model toggling free → grant order 0,1,2,3,0; no requester granted twice before the others.
- Stale free: receiver model with one-cycle-lagged registered free → exactly 4 put cycles per packet, never 5 or 8 back-to-back; second grant only after free falls and rises.
- Backpressure: free=0 held 10 cycles with req=4'b0100 → grant=0, put=0, busy=0 throughout; free=1 → grant[2] the next cycle.
- Request during SEND: req[3] rises at the second byte → no grant during SEND; grant[3] at first eligible IDLE cycle with correct byte order.
- Reset mid-packet: rst=1 after byte 1 → put=0 and payload=0 immediately; after release, prio_ptr=0, cnt=0, and req=4'b1001 grants 0 first.
